// File: rtl/we_run_sequencer_if.sv
// Host-decode / WE-core handshake bundle for the run sequencer.
// The slave modport is the sequencer; the master modport is the host side.
interface we_run_sequencer_if #(
  parameter int LDO_W = 8,
  parameter int RUN_W = 16,
  parameter int TMR_W = 24
);
  logic             start;
  logic             abort;
  logic [RUN_W-1:0] n_runs;
  logic [LDO_W-1:0] ldo_mask;
  logic             ion_en;
  logic [TMR_W-1:0] t_settle;
  logic [TMR_W-1:0] t_gap;
  logic [TMR_W-1:0] t_timeout;
  logic             done_spi;
  logic             done_task;
  logic             full_ppfifo;
  logic             drain_ack;
  logic [LDO_W-1:0] ldo_en;
  logic             ion_sw;
  logic             trigger_config;
  logic             trigger_task;
  logic             busy;
  logic             seq_done;
  logic             err_timeout;
  logic [RUN_W-1:0] run_cnt;
  logic [2:0]       state;

  modport master (
    output start, abort, n_runs, ldo_mask, ion_en, t_settle, t_gap, t_timeout,
           done_spi, done_task, full_ppfifo, drain_ack,
    input  ldo_en, ion_sw, trigger_config, trigger_task, busy, seq_done,
           err_timeout, run_cnt, state
  );

  modport slave (
    input  start, abort, n_runs, ldo_mask, ion_en, t_settle, t_gap, t_timeout,
           done_spi, done_task, full_ppfifo, drain_ack,
    output ldo_en, ion_sw, trigger_config, trigger_task, busy, seq_done,
           err_timeout, run_cnt, state
  );
endinterface

// File: rtl/we_run_sequencer.sv
// Campaign sequencer on the WE clock: LDO power-up/settle, one SPI config,
// N task runs separated by gaps (with ping-pong hold), then power-down.
module we_run_sequencer #(
  parameter int LDO_W = 8,
  parameter int RUN_W = 16,
  parameter int TMR_W = 24
) (
  input logic               clk,
  input logic               rst_n,
  we_run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PWR_UP = 3'd1,
    CONFIG = 3'd2,
    TASK   = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5,
    PWR_DN = 3'd6
  } st_e;

  st_e              st;
  logic [RUN_W-1:0] n_runs_l, run_cnt, run_nxt;
  logic [TMR_W-1:0] settle_l, gap_l, tmo_l, tmr;
  logic [LDO_W-1:0] ldo_en;
  logic             ion_en_l, ion_sw, trig_cfg, trig_tsk, seq_done, err_timeout;
  logic             spi_q, task_q;
  logic             spi_rise, task_rise, tmo_hit, settle_end, gap_end;

  assign spi_rise   = bus.done_spi & ~spi_q;
  assign task_rise  = bus.done_task & ~task_q;
  // One shared timer: settle, gap and done-wait never overlap.
  assign tmo_hit    = (tmo_l != '0) && (tmr == tmo_l - TMR_W'(1));
  assign settle_end = (tmr == settle_l - TMR_W'(1));
  assign gap_end    = (tmr == gap_l - TMR_W'(1));
  assign run_nxt    = (run_cnt == '1) ? run_cnt : run_cnt + RUN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      n_runs_l    <= '0;
      run_cnt     <= '0;
      settle_l    <= '0;
      gap_l       <= '0;
      tmo_l       <= '0;
      tmr         <= '0;
      ldo_en      <= '0;
      ion_en_l    <= 1'b0;
      ion_sw      <= 1'b0;
      trig_cfg    <= 1'b0;
      trig_tsk    <= 1'b0;
      seq_done    <= 1'b0;
      err_timeout <= 1'b0;
      spi_q       <= 1'b0;
      task_q      <= 1'b0;
    end else begin
      spi_q    <= bus.done_spi;
      task_q   <= bus.done_task;
      trig_cfg <= 1'b0;
      trig_tsk <= 1'b0;
      seq_done <= 1'b0;
      tmr      <= tmr + TMR_W'(1);
      if (st != IDLE && st != PWR_DN && bus.abort) begin
        st     <= PWR_DN;
        ldo_en <= '0;
        ion_sw <= 1'b0;
      end else begin
        case (st)
          IDLE: if (bus.start) begin
            if (bus.n_runs == '0) begin
              seq_done <= 1'b1;
            end else begin
              st          <= PWR_UP;
              err_timeout <= 1'b0;
              run_cnt     <= '0;
              n_runs_l    <= bus.n_runs;
              settle_l    <= (bus.t_settle == '0) ? TMR_W'(1) : bus.t_settle;
              gap_l       <= (bus.t_gap == '0) ? TMR_W'(1) : bus.t_gap;
              tmo_l       <= bus.t_timeout;
              ion_en_l    <= bus.ion_en;
              ldo_en      <= bus.ldo_mask;
              tmr         <= '0;
            end
          end
          PWR_UP: if (settle_end) begin
            st       <= CONFIG;
            trig_cfg <= 1'b1;
            tmr      <= '0;
          end
          // The trigger cycle itself never accepts a done edge.
          CONFIG: if (!trig_cfg && spi_rise) begin
            st       <= TASK;
            trig_tsk <= 1'b1;
            ion_sw   <= ion_en_l;
            tmr      <= '0;
          end else if (tmo_hit) begin
            st          <= PWR_DN;
            err_timeout <= 1'b1;
            ldo_en      <= '0;
          end
          TASK: if (!trig_tsk && task_rise) begin
            run_cnt <= run_nxt;
            ion_sw  <= 1'b0;
            tmr     <= '0;
            if (run_nxt == n_runs_l) begin
              st     <= PWR_DN;
              ldo_en <= '0;
            end else if (bus.full_ppfifo) begin
              st <= HOLD;
            end else begin
              st <= GAP;
            end
          end else if (tmo_hit) begin
            st          <= PWR_DN;
            err_timeout <= 1'b1;
            ldo_en      <= '0;
            ion_sw      <= 1'b0;
          end
          HOLD: if (bus.drain_ack) begin
            st  <= GAP;
            tmr <= '0;
          end
          GAP: if (gap_end) begin
            st       <= TASK;
            trig_tsk <= 1'b1;
            ion_sw   <= ion_en_l;
            tmr      <= '0;
          end
          PWR_DN: begin
            st       <= IDLE;
            seq_done <= 1'b1;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  // Abort in a state's first cycle must swallow that state's trigger pulse.
  assign bus.trigger_config = trig_cfg & ~bus.abort;
  assign bus.trigger_task   = trig_tsk & ~bus.abort;
  assign bus.ldo_en         = ldo_en;
  assign bus.ion_sw         = ion_sw;
  assign bus.busy           = (st != IDLE);
  assign bus.seq_done       = seq_done;
  assign bus.err_timeout    = err_timeout;
  assign bus.run_cnt        = run_cnt;
  assign bus.state          = st;

endmodule

// File: tb/tb_we_run_sequencer.sv
// Directed bench for we_run_sequencer: full campaign, zero-run start, hold,
// timeout, aborts and mid-campaign reset.
module tb_we_run_sequencer;
  localparam int LDO_W = 8;
  localparam int RUN_W = 16;
  localparam int TMR_W = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  we_run_sequencer_if #(.LDO_W(LDO_W), .RUN_W(RUN_W), .TMR_W(TMR_W)) bus ();
  we_run_sequencer #(.LDO_W(LDO_W), .RUN_W(RUN_W), .TMR_W(TMR_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0;
  int cyc = 0, spi_dly = 0, task_dly = 0, spi_at = -1, task_at = -1;
  int n_cfg, n_tsk, n_done, last_cfg, last_done, s0, bud, hold_bad;
  int tsk_c[8];
  bit ldo_bad, ion_bad, busy_seen, ldo_seen;
  logic [LDO_W-1:0] mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_cfg = 0; n_tsk = 0; n_done = 0; last_cfg = -1; last_done = -1;
    spi_at = -1; task_at = -1;
    ldo_bad = 0; ion_bad = 0; busy_seen = 0; ldo_seen = 0;
  endtask

  // One clock: observe outputs just after the edge, then drive done responses.
  task automatic step();
    @(posedge clk); #1; cyc++;
    if (bus.trigger_config) begin
      n_cfg++; last_cfg = cyc;
      if (spi_dly > 0) spi_at = cyc + spi_dly;
    end
    if (bus.trigger_task) begin
      if (n_tsk < 8) tsk_c[n_tsk] = cyc;
      n_tsk++;
      if (task_dly > 0) task_at = cyc + task_dly;
    end
    if (bus.seq_done) begin n_done++; last_done = cyc; end
    if (bus.busy) busy_seen = 1;
    if (bus.ldo_en != '0) ldo_seen = 1;
    if (bus.busy && bus.state != 3'd6 && bus.ldo_en != mask) ldo_bad = 1;
    if (bus.state == 3'd3 && bus.ion_sw != bus.ion_en) ion_bad = 1;
    bus.done_spi  = (cyc == spi_at);
    bus.done_task = (cyc == task_at);
  endtask

  task automatic cfg(input int runs, input int settle, input int gap, input int tmo,
                     input int sd, input int td);
    clr();
    bus.n_runs = RUN_W'(runs); bus.t_settle = TMR_W'(settle);
    bus.t_gap = TMR_W'(gap); bus.t_timeout = TMR_W'(tmo);
    spi_dly = sd; task_dly = td;
  endtask

  task automatic go();
    s0 = cyc; bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 0; bus.abort = 0; bus.n_runs = '0; bus.ion_en = 1'b1;
    mask = 8'hA5; bus.ldo_mask = mask;
    bus.t_settle = '0; bus.t_gap = '0; bus.t_timeout = '0;
    bus.done_spi = 0; bus.done_task = 0; bus.full_ppfifo = 0; bus.drain_ack = 0;
    clr();
    repeat (3) step();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_outs", {bus.ldo_en, bus.ion_sw, bus.trigger_config, bus.trigger_task,
                     bus.busy, bus.seq_done, bus.err_timeout}, 0);
    chk("rst_run_cnt", 32'(bus.run_cnt), 0);
    rst_n = 1'b1; step();

    // Full campaign: 3 runs, settle 4, gap 2, done_spi +3, done_task +10.
    cfg(3, 4, 2, 0, 3, 10); go();
    bud = 200;
    while (n_done == 0 && bud > 0) begin step(); bud--; end
    chk("A_seq_done", n_done, 1);
    chk("A_n_cfg", n_cfg, 1);
    chk("A_n_tsk", n_tsk, 3);
    chk("A_cfg_ofs", last_cfg - s0, 5);
    chk("A_tsk1_ofs", tsk_c[0] - last_cfg, 4);
    chk("A_tsk2_gap", tsk_c[1] - tsk_c[0], 13);
    chk("A_tsk3_gap", tsk_c[2] - tsk_c[1], 13);
    chk("A_done_ofs", last_done - last_cfg, 42);
    chk("A_ldo_mask", ldo_bad, 0);
    chk("A_ion_sw", ion_bad, 0);
    chk("A_run_cnt", 32'(bus.run_cnt), 3);
    chk("A_end", {bus.ldo_en, bus.busy, bus.state}, 0);

    // Zero-run start.
    cfg(0, 4, 2, 0, 3, 10); go();
    chk("B_seq_done", bus.seq_done, 1);
    repeat (3) step();
    chk("B_quiet", {n_cfg[3:0], n_tsk[3:0], 3'(busy_seen), 3'(ldo_seen)}, 0);
    chk("B_n_done", n_done, 1);

    // Ping-pong full at first done_task, drain_ack 20 cycles later.
    cfg(2, 1, 1, 0, 2, 5); bus.full_ppfifo = 1'b1; go();
    bud = 100;
    while (bus.state != 3'd4 && bud > 0) begin step(); bud--; end
    chk("C_hold", 32'(bus.state), 4);
    chk("C_hold_ion", bus.ion_sw, 0);
    chk("C_run1", 32'(bus.run_cnt), 1);
    bus.full_ppfifo = 1'b0; hold_bad = 0;
    repeat (20) begin step(); if (bus.state != 3'd4) hold_bad++; end
    chk("C_hold_stays", hold_bad, 0);
    bus.drain_ack = 1'b1; step(); bus.drain_ack = 1'b0;
    chk("C_gap", 32'(bus.state), 5);
    step();
    chk("C_tsk2", {29'(n_tsk), bus.state}, {29'd2, 3'd3});
    bud = 100;
    while (n_done == 0 && bud > 0) begin step(); bud--; end
    chk("C_done", {31'(n_done), 1'b0}, {31'd1, 1'b0});
    chk("C_run_cnt", 32'(bus.run_cnt), 2);

    // done_spi never arrives; 50-cycle timeout.
    cfg(1, 1, 1, 50, 0, 5); go();
    bud = 200;
    while (!bus.err_timeout && bud > 0) begin step(); bud--; end
    chk("D_err", bus.err_timeout, 1);
    chk("D_tmo_ofs", cyc - last_cfg, 50);
    chk("D_pwr_dn", 32'(bus.state), 6);
    step();
    chk("D_seq_done", {bus.seq_done, bus.err_timeout, bus.state}, {1'b1, 1'b1, 3'd0});
    chk("D_no_tsk", n_tsk, 0);

    // Abort during the second TASK run.
    cfg(3, 1, 1, 0, 2, 4); go();
    chk("E_err_clr", bus.err_timeout, 0);
    bud = 100;
    while (n_tsk < 2 && bud > 0) begin step(); bud--; end
    repeat (2) step();
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    chk("E_abort_st", 32'(bus.state), 6);
    chk("E_abort_outs", {bus.ldo_en, bus.ion_sw}, 0);
    chk("E_run_frozen", 32'(bus.run_cnt), 1);
    step();
    chk("E_seq_done", bus.seq_done, 1);
    repeat (4) step();
    chk("E_n_tsk", n_tsk, 2);

    // Abort on the first CONFIG cycle.
    cfg(2, 3, 1, 0, 2, 4); go();
    repeat (2) step();
    @(posedge clk); #1; cyc++;
    bus.abort = 1'b1; #1;
    chk("F_cfg_first", 32'(bus.state), 2);
    chk("F_no_trig", bus.trigger_config, 0);
    step(); bus.abort = 1'b0;
    chk("F_pwr_dn", 32'(bus.state), 6);
    step();
    chk("F_seq_done", bus.seq_done, 1);
    chk("F_run_cnt", {29'(n_cfg), 3'(bus.run_cnt)}, 0);

    // Reset in the middle of GAP.
    cfg(2, 1, 10, 0, 2, 3); go();
    bud = 100;
    while (bus.state != 3'd5 && bud > 0) begin step(); bud--; end
    chk("G_gap", 32'(bus.state), 5);
    repeat (2) step();
    rst_n = 1'b0; step();
    chk("G_rst_outs", {bus.ldo_en, bus.ion_sw, bus.trigger_config, bus.trigger_task,
                       bus.busy, bus.seq_done, bus.err_timeout, bus.state}, 0);
    chk("G_rst_run", 32'(bus.run_cnt), 0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("G_no_done", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/we_run_sequencer.md
Name: we_run_sequencer

Overview:
- Sequences one electrochemical measurement campaign on the 512 kHz WE clock domain: LDO power-up and settle, one SPI configuration, then N task runs with inter-run gaps, then power-down.
- Sits between the host WireIn/TriggerIn decode and the WE core. It drives trigger_config, trigger_task, ldo_en and ion_sw, and consumes done_spi, done_task and full_ppfifo.
- Replaces manual host-timed triggering.

Parameters:
- LDO_W, 8, width of LDO enable mask
- RUN_W, 16, width of run count and run counter
- TMR_W, 24, width of settle, gap and timeout counters

Ports:
- clk  in  1  WE clock (512 kHz)
- rst_n  in  1  synchronous reset, active-low
- start  in  1  single-cycle pulse; begins a campaign
- abort  in  1  single-cycle pulse; terminates the campaign
- n_runs  in  RUN_W  number of task runs
- ldo_mask  in  LDO_W  LDO enables applied during the campaign
- ion_en  in  1  enables ion_sw during task runs
- t_settle  in  TMR_W  LDO settle cycles
- t_gap  in  TMR_W  idle cycles between runs
- t_timeout  in  TMR_W  max cycles waiting for done_spi/done_task; 0 disables
- done_spi  in  1  SPI configuration complete (level or pulse)
- done_task  in  1  task complete (level or pulse)
- full_ppfifo  in  1  ping-pong buffer full
- drain_ack  in  1  pulse from host: full half drained
- ldo_en  out  LDO_W  LDO enables (registered)
- ion_sw  out  1  ion switch (registered)
- trigger_config  out  1  one-cycle config trigger
- trigger_task  out  1  one-cycle task trigger
- busy  out  1  high in any state except IDLE
- seq_done  out  1  one-cycle pulse at campaign end
- err_timeout  out  1  sticky timeout flag
- run_cnt  out  RUN_W  completed runs in the current campaign
- state  out  3  encoded FSM state for a status WireOut

Behaviour:
Reset (rst_n=0 at a clk edge):
- All outputs go to 0 and state=IDLE.
- All counters and edge-detect registers go to 0.

Edge detection:
- done_spi and done_task are edge-detected against registered copies. Only rising edges count.
- Edges are accepted from the cycle after the corresponding trigger onward.

FSM states (encoding):
- IDLE=0, PWR_UP=1, CONFIG=2, TASK=3, HOLD=4, GAP=5, PWR_DN=6.

IDLE:
- start with n_runs=0: seq_done pulses the next cycle and state stays IDLE. No LDO activity.
- start with n_runs>0: err_timeout and run_cnt are cleared, n_runs/t_* are latched, and the FSM goes to PWR_UP.

PWR_UP:
- ldo_en=ldo_mask is registered on entry.
- The FSM stays max(t_settle,1) cycles, then goes to CONFIG.

CONFIG:
- trigger_config=1 in the first cycle only.
- A done_spi rising edge moves the FSM to TASK.

TASK:
- trigger_task=1 in the first cycle only.
- ion_sw=ion_en for the whole state.
- A done_task rising edge increments run_cnt (saturating).
- Next state after that edge:
  - run_cnt(new)==n_runs → PWR_DN.
  - Else if full_ppfifo=1 → HOLD.
  - Else → GAP.

HOLD:
- ion_sw=0.
- Waits for drain_ack, then goes to GAP.
- The timeout does not apply here.

GAP:
- Stays max(t_gap,1) cycles, then goes to TASK.
- Configuration is not repeated.

PWR_DN:
- ldo_en=0 and ion_sw=0.
- Lasts exactly 1 cycle, then IDLE, with seq_done=1 in the same cycle as the IDLE transition.

Timeout:
- A wait counter resets on entry to CONFIG and TASK.
- If t_timeout≠0 and the count reaches t_timeout with no done edge: err_timeout=1 and the FSM goes to PWR_DN.

Abort:
- abort in any non-IDLE state forces PWR_DN on the next cycle, overriding all other transitions.
- No trigger pulse is issued in the abort cycle, even on a state's first cycle.
- abort in IDLE is ignored.

Other rules:
- start in a non-IDLE state is ignored.
- If done edge and abort/timeout occur in the same cycle, abort wins, then done, then timeout. The run is counted if done is present with timeout only.
- Latched parameters are stable for the whole campaign; input changes mid-campaign have no effect.
- Reset mid-campaign: outputs are 0 at the next edge. No seq_done is issued.

Test Plan:
- n_runs=3, t_settle=4, t_gap=2, timeout=0, done_spi 3 cycles after trigger_config, done_task 10 cycles after each trigger_task → required response:
  - ldo_en=mask for the whole campaign.
  - 1 trigger_config, 3 trigger_task separated by 2 gap cycles.
  - run_cnt=3, then seq_done pulse and ldo_en=0.
- n_runs=0 start → seq_done 1 cycle later; ldo_en, trigger_config and trigger_task never asserted; busy stays 0.
- n_runs=2, full_ppfifo=1 at the first done_task → state=4 holds until a drain_ack injected 20 cycles later, then GAP and the second trigger_task.
- t_timeout=50, done_spi never asserted → err_timeout=1 at cycle 50 after trigger_config, then PWR_DN, seq_done, and no trigger_task.
- abort in the second TASK run and abort on the first CONFIG cycle → PWR_DN next cycle, no trigger pulse in the abort cycle, run_cnt frozen at 1.
- rst_n=0 mid-GAP → all outputs 0 at the next edge, state=IDLE, no seq_done.
